// File: rtl/fan_run_ctrl.sv
// Fan run controller: power / speed / timed-shutdown sequencing with a BCD
// mm:ss countdown and a single-cycle shutdown request on expiry.
module fan_run_ctrl #(
    parameter logic [15:0] PRESET1 = 16'h0003,
    parameter logic [15:0] PRESET2 = 16'h0004,
    parameter logic [15:0] PRESET3 = 16'h0005,
    parameter logic [7:0]  DUTY1   = 8'd64,
    parameter logic [7:0]  DUTY2   = 8'd128,
    parameter logic [7:0]  DUTY3   = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_pwr,
    input  logic        btn_speed,
    input  logic        btn_timer,
    input  logic        tick_sec,
    output logic        fan_on,
    output logic [1:0]  speed,
    output logic [7:0]  duty,
    output logic [15:0] remain,
    output logic [2:0]  timer_led,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN_CONT,
        S_RUN_TIMED,
        S_EXPIRE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  stage, stage_nxt;
    logic [1:0]  speed_nxt, speed_step;
    logic [15:0] remain_nxt;
    logic        timeout_nxt;

    // BCD mm:ss decrement; only called with a value above 0001, so the
    // minute-tens digit never has to borrow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = v;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    function automatic logic [15:0] preset_for(input logic [1:0] stg);
        case (stg)
            2'd1:    return PRESET1;
            2'd2:    return PRESET2;
            2'd3:    return PRESET3;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] duty_for(input logic [1:0] spd);
        case (spd)
            2'd1:    return DUTY1;
            2'd2:    return DUTY2;
            2'd3:    return DUTY3;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [2:0] led_for(input logic [1:0] stg);
        case (stg)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign speed_step = (speed == 2'd3) ? 2'd1 : speed + 2'd1;

    // Next-state decode. btn_pwr overrides everything; btn_timer drops a
    // coincident tick; btn_speed is orthogonal to the timer path.
    always_comb begin
        state_nxt   = state;
        speed_nxt   = speed;
        stage_nxt   = stage;
        remain_nxt  = remain;
        timeout_nxt = 1'b0;
        case (state)
            S_OFF: begin
                if (btn_pwr) begin
                    state_nxt  = S_RUN_CONT;
                    speed_nxt  = 2'd1;
                    stage_nxt  = 2'd0;
                    remain_nxt = '0;
                end
            end
            S_RUN_CONT: begin
                if (btn_pwr) begin
                    state_nxt  = S_OFF;
                    speed_nxt  = 2'd0;
                    stage_nxt  = 2'd0;
                    remain_nxt = '0;
                end else begin
                    if (btn_speed) speed_nxt = speed_step;
                    if (btn_timer) begin
                        state_nxt  = S_RUN_TIMED;
                        stage_nxt  = 2'd1;
                        remain_nxt = PRESET1;
                    end
                end
            end
            S_RUN_TIMED: begin
                if (btn_pwr) begin
                    state_nxt  = S_OFF;
                    speed_nxt  = 2'd0;
                    stage_nxt  = 2'd0;
                    remain_nxt = '0;
                end else begin
                    if (btn_speed) speed_nxt = speed_step;
                    if (btn_timer) begin
                        if (stage == 2'd3) begin
                            state_nxt  = S_RUN_CONT;
                            stage_nxt  = 2'd0;
                            remain_nxt = '0;
                        end else begin
                            stage_nxt  = stage + 2'd1;
                            remain_nxt = preset_for(stage + 2'd1);
                        end
                    end else if (tick_sec) begin
                        if (remain <= 16'h0001) begin
                            remain_nxt  = '0;
                            state_nxt   = S_EXPIRE;
                            timeout_nxt = 1'b1;
                        end else begin
                            remain_nxt = bcd_dec(remain);
                        end
                    end
                end
            end
            default: begin
                state_nxt  = S_OFF;
                speed_nxt  = 2'd0;
                stage_nxt  = 2'd0;
                remain_nxt = '0;
            end
        endcase
    end

    // State and all outputs registered together so they change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_OFF;
            stage     <= 2'd0;
            speed     <= 2'd0;
            duty      <= '0;
            remain    <= '0;
            timer_led <= '0;
            timeout   <= 1'b0;
            fan_on    <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage     <= stage_nxt;
            speed     <= speed_nxt;
            duty      <= duty_for(speed_nxt);
            remain    <= remain_nxt;
            timer_led <= led_for(stage_nxt);
            timeout   <= timeout_nxt;
            fan_on    <= (state_nxt != S_OFF);
        end
    end

endmodule

// File: tb/tb_fan_run_ctrl.sv
// Directed bench for fan_run_ctrl: default-preset instance plus a second
// instance with overridden presets for borrow and zero-preset cases.
module tb_fan_run_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_pwr = 1'b0, btn_speed = 1'b0, btn_timer = 1'b0, tick_sec = 1'b0;

    logic        fan_on, timeout;
    logic [1:0]  speed;
    logic [7:0]  duty;
    logic [15:0] remain;
    logic [2:0]  timer_led;

    logic        b_fan_on, b_timeout;
    logic [1:0]  b_speed;
    logic [7:0]  b_duty;
    logic [15:0] b_remain;
    logic [2:0]  b_timer_led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fan_run_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .btn_pwr(btn_pwr), .btn_speed(btn_speed), .btn_timer(btn_timer), .tick_sec(tick_sec),
        .fan_on(fan_on), .speed(speed), .duty(duty), .remain(remain),
        .timer_led(timer_led), .timeout(timeout)
    );

    fan_run_ctrl #(
        .PRESET1(16'h0100),
        .PRESET2(16'h1000),
        .PRESET3(16'h0000)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .btn_pwr(btn_pwr), .btn_speed(btn_speed), .btn_timer(btn_timer), .tick_sec(tick_sec),
        .fan_on(b_fan_on), .speed(b_speed), .duty(b_duty), .remain(b_remain),
        .timer_led(b_timer_led), .timeout(b_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of pulses, then return 1 time unit after the edge.
    task automatic step(input logic p, input logic s, input logic t, input logic k);
        @(negedge clk);
        btn_pwr = p; btn_speed = s; btn_timer = t; tick_sec = k;
        @(posedge clk);
        #1;
        btn_pwr = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0; tick_sec = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic f, input logic [1:0] sp, input logic [7:0] d,
                         input logic [15:0] r, input logic [2:0] l, input logic to);
        check({tag, ".fan_on"}, 32'(fan_on), 32'(f));
        check({tag, ".speed"}, 32'(speed), 32'(sp));
        check({tag, ".duty"}, 32'(duty), 32'(d));
        check({tag, ".remain"}, 32'(remain), 32'(r));
        check({tag, ".led"}, 32'(timer_led), 32'(l));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        chk_a("reset", 1'b0, 2'd0, 8'd0, 16'h0000, 3'b000, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // OFF ignores speed / timer / tick
        step(0, 1, 0, 1);
        step(0, 0, 1, 0);
        chk_a("off_ignore", 1'b0, 2'd0, 8'd0, 16'h0000, 3'b000, 1'b0);

        // Power on
        step(1, 0, 0, 0);
        chk_a("pwr_on", 1'b1, 2'd1, 8'd64, 16'h0000, 3'b000, 1'b0);

        // Speed stepping wraps 3 -> 1
        step(0, 1, 0, 0); chk_a("spd2", 1'b1, 2'd2, 8'd128, 16'h0000, 3'b000, 1'b0);
        step(0, 1, 0, 0); chk_a("spd3", 1'b1, 2'd3, 8'd255, 16'h0000, 3'b000, 1'b0);
        step(0, 1, 0, 0); chk_a("spd1", 1'b1, 2'd1, 8'd64, 16'h0000, 3'b000, 1'b0);

        // Stage 1 countdown to expiry
        step(0, 0, 1, 0); chk_a("t1_load", 1'b1, 2'd1, 8'd64, 16'h0003, 3'b001, 1'b0);
        step(0, 0, 0, 1); check("cd.r2", 32'(remain), 32'h0002);
        step(0, 0, 0, 1); check("cd.r1", 32'(remain), 32'h0001);
        step(0, 0, 0, 1);
        check("exp.remain", 32'(remain), 32'h0000);
        check("exp.timeout", 32'(timeout), 32'd1);
        check("exp.fan_on", 32'(fan_on), 32'd1);
        step(0, 0, 0, 0); chk_a("post_exp", 1'b0, 2'd0, 8'd0, 16'h0000, 3'b000, 1'b0);
        step(0, 0, 0, 0); check("post_exp2.timeout", 32'(timeout), 32'd0);

        // Stage cycling back to continuous
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); chk_a("cyc1", 1'b1, 2'd1, 8'd64, 16'h0003, 3'b001, 1'b0);
        step(0, 0, 1, 0); chk_a("cyc2", 1'b1, 2'd1, 8'd64, 16'h0004, 3'b010, 1'b0);
        step(0, 0, 1, 0); chk_a("cyc3", 1'b1, 2'd1, 8'd64, 16'h0005, 3'b100, 1'b0);
        step(0, 0, 1, 0); chk_a("cyc0", 1'b1, 2'd1, 8'd64, 16'h0000, 3'b000, 1'b0);

        // Simultaneous events
        step(0, 0, 1, 0);
        step(0, 0, 0, 1); check("sim.r2", 32'(remain), 32'h0002);
        step(0, 0, 1, 1); chk_a("tmr_tick", 1'b1, 2'd1, 8'd64, 16'h0004, 3'b010, 1'b0);
        step(0, 0, 0, 1); check("restart.r3", 32'(remain), 32'h0003);
        step(0, 1, 0, 1); chk_a("spd_tick", 1'b1, 2'd2, 8'd128, 16'h0002, 3'b010, 1'b0);
        step(0, 0, 0, 1); check("sim.r1", 32'(remain), 32'h0001);
        step(1, 0, 0, 1); chk_a("pwr_tick", 1'b0, 2'd0, 8'd0, 16'h0000, 3'b000, 1'b0);
        step(0, 0, 0, 0); check("pwr_tick2.timeout", 32'(timeout), 32'd0);

        // Async reset mid-countdown
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        check("pre_rst.remain", 32'(remain), 32'h0002);
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("mid_rst", 1'b0, 2'd0, 8'd0, 16'h0000, 3'b000, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Overridden presets: borrow across digits and zero preset
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); check("b.load1", 32'(b_remain), 32'h0100);
        step(0, 0, 0, 1); check("b.0059", 32'(b_remain), 32'h0059);
        step(0, 0, 0, 1); check("b.0058", 32'(b_remain), 32'h0058);
        step(0, 0, 1, 0);
        check("b.load2", 32'(b_remain), 32'h1000);
        check("b.led2", 32'(b_timer_led), 32'(3'b010));
        step(0, 0, 0, 1); check("b.0959", 32'(b_remain), 32'h0959);
        step(0, 0, 1, 0);
        check("b.load3", 32'(b_remain), 32'h0000);
        check("b.led3", 32'(b_timer_led), 32'(3'b100));
        check("b.load3.timeout", 32'(b_timeout), 32'd0);
        check("b.load3.fan", 32'(b_fan_on), 32'd1);
        step(0, 0, 0, 1);
        check("b.zero_exp.timeout", 32'(b_timeout), 32'd1);
        check("b.zero_exp.remain", 32'(b_remain), 32'h0000);
        step(0, 0, 0, 0);
        check("b.post.fan", 32'(b_fan_on), 32'd0);
        check("b.post.duty", 32'(b_duty), 32'd0);
        check("b.post.timeout", 32'(b_timeout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
